// File: rtl/cms_ctrl_write_arbiter.sv
// Round-robin share of the monitor control-write port; each command plays out as SETUP -> HIGH -> LOW.
// Handshake at T gives we=1 on T+2..T+1+HIGH_CYCLES and done at T+1+HIGH+LOW; req_ready is low whenever busy.
module cms_ctrl_write_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 64,
  parameter int HIGH_CYCLES = 2,
  parameter int LOW_CYCLES  = 2,
  localparam int GW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CNT_W = $clog2(((HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES) + 1)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
  output logic [ADDR_WIDTH-1:0]            ctrl_addr,
  output logic [DATA_WIDTH-1:0]            ctrl_wdata,
  output logic                             ctrl_write_enable,
  output logic                             busy,
  output logic [GW-1:0]                    grant_id,
  output logic                             done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_HIGH  = 2'd2,
    ST_LOW   = 2'd3
  } state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [GW-1:0]      rr_ptr;
  logic [GW-1:0]      win;
  logic               any_vld;
  logic               hs;
  logic [NUM_REQ-1:0] sel;
  int                 idx;

  // Search starts at rr_ptr and wraps, so the last winner drops to lowest priority.
  always_comb begin
    win     = '0;
    any_vld = 1'b0;
    idx     = 0;
    sel     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      sel = req_valid >> idx;
      if (!any_vld && sel[0]) begin
        any_vld = 1'b1;
        win     = GW'(idx);
      end
    end
  end

  assign hs        = (state == ST_IDLE) && any_vld;
  assign req_ready = (rst_n && hs) ? (NUM_REQ'(1) << win) : '0;
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_LOW) && (cnt == '0);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      ST_IDLE: begin
        if (any_vld) state_n = ST_SETUP;
      end
      ST_SETUP: begin
        state_n = ST_HIGH;
        cnt_n   = CNT_W'(HIGH_CYCLES - 1);
      end
      ST_HIGH: begin
        if (cnt == '0) begin
          state_n = ST_LOW;
          cnt_n   = CNT_W'(LOW_CYCLES - 1);
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      ST_LOW: begin
        if (cnt == '0) state_n = ST_IDLE;
        else           cnt_n   = cnt - CNT_W'(1);
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= ST_IDLE;
      cnt               <= '0;
      rr_ptr            <= '0;
      grant_id          <= '0;
      ctrl_addr         <= '0;
      ctrl_wdata        <= '0;
      ctrl_write_enable <= 1'b0;
    end else begin
      state             <= state_n;
      cnt               <= cnt_n;
      // Registered from the next state so the monitor sees one glitch-free rising edge.
      ctrl_write_enable <= (state_n == ST_HIGH);
      if (hs) begin
        grant_id   <= win;
        rr_ptr     <= GW'((int'(win) + 1) % NUM_REQ);
        ctrl_addr  <= req_addr[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
        ctrl_wdata <= req_wdata[int'(win)*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_cms_ctrl_write_arbiter.sv
// Directed bench: a 2-requester H=2/L=2 instance and a 1-requester H=1/L=1 instance.
module tb_cms_ctrl_write_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]   valid;
  logic [1:0]   ready;
  logic [15:0]  addr;
  logic [127:0] wdata;
  logic [7:0]   ctrl_addr;
  logic [63:0]  ctrl_wdata;
  logic         we, busy, done;
  logic [0:0]   gid;

  logic         v1, r1;
  logic [7:0]   a1, ca1;
  logic [63:0]  d1, cd1;
  logic         we1, busy1, done1;
  logic [0:0]   gid1;

  int n_cmp = 0;
  int n_err = 0;
  int pulses = 0;

  cms_ctrl_write_arbiter #(.NUM_REQ(2), .ADDR_WIDTH(8), .DATA_WIDTH(64),
                           .HIGH_CYCLES(2), .LOW_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(valid), .req_ready(ready),
    .req_addr(addr), .req_wdata(wdata), .ctrl_addr(ctrl_addr), .ctrl_wdata(ctrl_wdata),
    .ctrl_write_enable(we), .busy(busy), .grant_id(gid), .done(done));

  cms_ctrl_write_arbiter #(.NUM_REQ(1), .ADDR_WIDTH(8), .DATA_WIDTH(64),
                           .HIGH_CYCLES(1), .LOW_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(v1), .req_ready(r1),
    .req_addr(a1), .req_wdata(d1), .ctrl_addr(ca1), .ctrl_wdata(cd1),
    .ctrl_write_enable(we1), .busy(busy1), .grant_id(gid1), .done(done1));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    valid = 2'b11;
    addr  = {8'h21, 8'h10};
    wdata = {64'hBBBB_0000_0000_0021, 64'hAAAA_0000_0000_0010};
    v1 = 1'b0; a1 = 8'h00; d1 = 64'h0;
    #1;
    chk("rst_ready", ready, 2'b00);
    chk("rst_we", we, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_addr", ctrl_addr, 8'h00);
    chk("rst_wdata", ctrl_wdata, 64'h0);
    chk("rst_gid", gid, 1'b0);
    chk("rst_done", done, 1'b0);
    valid = 2'b00;
    nxt(); nxt();
    rst_n = 1'b1;

    // Single write from requester 0
    nxt();
    valid = 2'b01; addr = {8'h21, 8'h06}; wdata = {64'h0, 64'h8000_0000};
    #1 chk("s1_ready_T", ready, 2'b01);
    chk("s1_busy_T", busy, 1'b0);
    nxt(); valid = 2'b00; #1;
    chk("s1_busy_T1", busy, 1'b1);
    chk("s1_we_T1", we, 1'b0);
    chk("s1_addr_T1", ctrl_addr, 8'h06);
    chk("s1_wdata_T1", ctrl_wdata, 64'h8000_0000);
    chk("s1_gid_T1", gid, 1'b0);
    nxt(); valid = 2'b10; #1;
    chk("s1_we_T2", we, 1'b1);
    chk("s1_ready_busy", ready, 2'b00);
    nxt();
    chk("s1_we_T3", we, 1'b1);
    chk("s1_addr_T3", ctrl_addr, 8'h06);
    nxt();
    chk("s1_we_T4", we, 1'b0);
    chk("s1_done_T4", done, 1'b0);
    nxt(); valid = 2'b00; #1;
    chk("s1_done_T5", done, 1'b1);
    chk("s1_we_T5", we, 1'b0);
    nxt();
    chk("s1_busy_T6", busy, 1'b0);
    chk("s1_done_T6", done, 1'b0);
    chk("s1_addr_idle", ctrl_addr, 8'h06);
    nxt();
    chk("s1_drop_not_taken", busy, 1'b0);

    // Reset asserted in the middle of HIGH
    nxt();
    valid = 2'b01; addr = {8'h21, 8'h0A}; wdata = {64'h0, 64'h55};
    #1 chk("s4_ready_T", ready, 2'b01);
    nxt(); valid = 2'b00;
    nxt(); nxt();
    chk("s4_we_T3", we, 1'b1);
    rst_n = 1'b0;
    valid = 2'b11;
    addr  = {8'h21, 8'h10};
    wdata = {64'hBBBB_0000_0000_0021, 64'hAAAA_0000_0000_0010};
    #1;
    chk("s4_we_async", we, 1'b0);
    chk("s4_busy_async", busy, 1'b0);
    chk("s4_addr_async", ctrl_addr, 8'h00);
    chk("s4_ready_rst", ready, 2'b00);
    nxt();
    rst_n = 1'b1;
    #1;
    chk("s4_rr_reset", ready, 2'b01);
    chk("s4_we_release", we, 1'b0);

    // Both requesters held valid: grants alternate
    nxt();
    chk("s2_gid0", gid, 1'b0);
    chk("s2_addr0", ctrl_addr, 8'h10);
    chk("s2_ready_busy", ready, 2'b00);
    repeat (4) nxt();
    chk("s2_done_T5", done, 1'b1);
    nxt();
    chk("s2_ready1_T6", ready, 2'b10);
    chk("s2_busy_T6", busy, 1'b0);
    nxt();
    chk("s2_gid1", gid, 1'b1);
    chk("s2_addr1", ctrl_addr, 8'h21);
    chk("s2_wdata1", ctrl_wdata, 64'hBBBB_0000_0000_0021);
    repeat (5) nxt();
    chk("s3_ready0_T12", ready, 2'b01);
    nxt();
    chk("s3_gid0_T13", gid, 1'b0);
    chk("s3_addr0_T13", ctrl_addr, 8'h10);
    repeat (5) nxt();
    chk("s3_ready1_T18", ready, 2'b10);
    nxt();
    chk("s3_gid1_T19", gid, 1'b1);
    valid = 2'b00;
    repeat (5) nxt();
    chk("s3_idle_end", busy, 1'b0);

    // Single requester, H=1 L=1, back-to-back commands
    nxt();
    v1 = 1'b1; a1 = 8'h02; d1 = 64'h1234;
    #1 chk("s5_ready_T", r1, 1'b1);
    for (int k = 1; k <= 9; k++) begin
      nxt();
      if (k == 1) begin a1 = 8'h03; d1 = 64'h5678; end
      if (k == 5) v1 = 1'b0;
      #1;
      if (we1) pulses++;
      chk($sformatf("s5_we_k%0d", k), we1, (k == 2) || (k == 6));
      chk($sformatf("s5_ready_k%0d", k), r1, k == 4);
      chk($sformatf("s5_done_k%0d", k), done1, (k == 3) || (k == 7));
      if (k == 2) begin
        chk("s5_addr_p1", ca1, 8'h02);
        chk("s5_wdata_p1", cd1, 64'h1234);
        chk("s5_gid", gid1, 1'b0);
      end
      if (k == 4) chk("s5_idle_k4", busy1, 1'b0);
      if (k == 6) chk("s5_addr_p2", ca1, 8'h03);
    end
    chk("s5_pulse_count", pulses, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
